// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 encodings and the mul/div FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// 2*W accumulator datapath: one unsigned shift-add (mul) or restoring shift-subtract (div)
// step per enable. acc_nx_o is the value the accumulator takes on the next enabled edge.
module muldiv_iter_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic           en_i,
  input  logic           is_div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] acc_nx_o
);

  logic [2*W-1:0] acc_q;
  logic [W-1:0]   b_q;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] shl;

  // Mul: {hi, lo} starts as {0, multiplier}; the multiplier drains out of lo as the product shifts in.
  // Div: {rem, quot} starts as {0, dividend}; diff[W] set means the trial subtraction borrowed.
  always_comb begin
    sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q};
    shl  = {acc_q[2*W-2:0], 1'b0};
    diff = acc_q[2*W-1:W-1] - {1'b0, b_q};
    if (is_div_i) begin
      if (!diff[W]) begin
        acc_nx_o = {diff[W-1:0], shl[W-1:1], 1'b1};
      end else begin
        acc_nx_o = shl;
      end
    end else if (acc_q[0]) begin
      acc_nx_o = {sum, acc_q[W-1:1]};
    end else begin
      acc_nx_o = {1'b0, acc_q[2*W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
    end else if (load_i) begin
      acc_q <= {{W{1'b0}}, a_i};
      b_q   <= b_i;
    end else if (en_i) begin
      acc_q <= acc_nx_o;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. Operates on magnitudes for XLEN cycles,
// then applies the sign fix-up; div-by-zero and signed overflow complete without iterating.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [1:0]      dbg_state
);
  import riscv_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [4:0]       rd_q, rd_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [4:0]       rd_out_q, rd_out_d;

  logic              a_signed, b_signed, sa_in, sb_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] acc_nx, prod;
  logic [XLEN-1:0]   quot, rem, final_res;
  logic              core_load, core_en;

  // Operand decode on the incoming instruction: magnitudes, signs and the non-iterating cases.
  always_comb begin
    a_signed = (funct3 == MULDIV_MULH) || (funct3 == MULDIV_MULHSU) ||
               (funct3 == MULDIV_DIV)  || (funct3 == MULDIV_REM);
    b_signed = (funct3 == MULDIV_MULH) || (funct3 == MULDIV_DIV) || (funct3 == MULDIV_REM);
    sa_in    = a_signed & op_a[XLEN-1];
    sb_in    = b_signed & op_b[XLEN-1];
    a_mag    = sa_in ? -op_a : op_a;
    b_mag    = sb_in ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    // Overflow DIV returns op_a itself (the most negative value); REM returns 0.
    if (div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else begin
      special_res = funct3[1] ? '0 : op_a;
    end
  end

  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_nx : acc_nx;
    quot = (sa_q ^ sb_q) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem  = sa_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    if (funct3_q[2]) begin
      final_res = funct3_q[1] ? rem : quot;
    end else if (funct3_q == MULDIV_MUL) begin
      final_res = prod[XLEN-1:0];
    end else begin
      final_res = prod[2*XLEN-1:XLEN];
    end
  end

  muldiv_iter_core #(.W(XLEN)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_i   (core_load),
    .en_i     (core_en),
    .is_div_i (funct3_q[2]),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .acc_nx_o (acc_nx)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    done_d    = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    core_load = 1'b0;
    core_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          funct3_d = funct3;
          rd_d     = rd_in;
          sa_d     = sa_in;
          sb_d     = sb_in;
          if (div_zero || div_ovf) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = special_res;
            rd_out_d = rd_in;
          end else begin
            state_d   = CALC;
            count_d   = '0;
            core_load = 1'b1;
          end
        end
      end
      CALC: begin
        core_en = 1'b1;
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = final_res;
          rd_out_d = rd_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush kills whatever completion would have been published on this edge.
    if (flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign stall     = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
  assign done      = done_q;
  assign result    = result_q;
  assign rd_out    = rd_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed and random RV32M ops against an arithmetic reference,
// with a queue-based scoreboard checking result, rd and completion cycle on every done pulse.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  // Expected entry: {done cycle[68:37], rd[36:32], result[31:0]}
  logic [68:0] exp_q[$];
  int          n_cmp;
  int          n_err;
  int          cyc;
  logic [31:0] last_res;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ae, be, p;
    int          si_a, si_b;
    si_a = a;
    si_b = b;
    ae = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    be = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ae * be;
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return si_a / si_b;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return si_a % si_b;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a posedge; issues one op and returns #1 after the posedge following DONE.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          n_stall;
    bit          sp;
    logic [4:0]  rd;
    logic [31:0] r;
    rd = 5'($urandom_range(1, 31));
    sp = is_special(f3, a, b);
    r  = ref_model(f3, a, b);
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    start  = 1'b1;
    exp_q.push_back({32'(cyc + (sp ? 1 : 33)), rd, r});
    last_res = r;
    n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      n_stall++;
      if (i == 1) begin
        op_a = $urandom;
        op_b = $urandom;
      end
    end
    chk("stall_cycles", n_stall, sp ? 32'd1 : 32'd33);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // ---------------- stimulus + monitor ----------------
  initial begin
    logic [68:0] e;
    logic [2:0]  f3;
    logic [31:0] a, b;
    cyc = 0; n_cmp = 0; n_err = 0; last_res = '0;
    reset = 1'b1; flush = 1'b0; start = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;

    fork
      forever begin
        @(negedge clk);
        if (done) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 result=0x%08h expected done=0 (cycle %0d)",
                     result, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("result", result, e[31:0]);
            chk("rd_out", {27'b0, rd_out}, {27'b0, e[36:32]});
            chk("done_cycle", 32'(cyc), e[68:37]);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_out", {27'b0, rd_out}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);

    // Directed arithmetic and special cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd0, 32'd0);

    // Flush mid-DIV at relative cycle 10: no done, result untouched, new op starts at 11
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd9; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_result_kept", result, last_res);
    chk("flush_stall_idle", {31'b0, stall}, 32'd0);
    run_op(3'd4, 32'hFFFF_FC18, 32'd7);

    // Flush together with start in IDLE: not accepted
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_start_not_accepted", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-MUL at relative cycle 20
    funct3 = 3'd0; op_a = 32'h1234_5678; op_b = 32'h9abc_def0; rd_in = 5'd17; start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_res = '0;
    chk("midreset_done", {31'b0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_rd_out", {27'b0, rd_out}, 32'd0);
    chk("midreset_stall", {31'b0, stall}, 32'd0);

    // Back-to-back MUL then DIV
    run_op(3'd0, 32'd123456, 32'd789);
    run_op(3'd4, 32'hFFFF_0000, 32'd10);

    // Random ops with biased operands
    for (int k = 0; k < 40; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op(f3, a, b);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
